// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: control for an in-place radix-2 DIT FFT built around a single
// shared butterfly. It steps through every stage, issues the A/B sample addresses and
// the twiddle index for each butterfly, and waits for the butterfly pipeline to empty
// between stages.
module fft_stage_sequencer #(
    parameter  int N        = 16,
    parameter  int W        = 16,
    parameter  int PIPE_LAT = 2,
    localparam int LOGN     = $clog2(N),
    localparam int SW       = $clog2(LOGN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            bf_valid,
    input  logic            bf_ready,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-2:0] tw_idx,
    output logic [SW-1:0]   stage
);

    // Index of the butterfly within a stage (0..N/2-1).
    localparam int BW = LOGN - 1;
    // The drain counter runs from 0 to PIPE_LAT-1. It keeps a width of one bit even
    // when PIPE_LAT is 0 or 1.
    localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int unsigned DRAIN_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam logic [BW-1:0]  B_LAST = BW'(N / 2 - 1);
    localparam logic [SW-1:0]  S_LAST = SW'(LOGN - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_LAST);

    // W only describes the sample path. It is checked here because nothing in this
    // block does arithmetic on it.
    if (N < 4 || (N & (N - 1)) != 0 || W < 1 || PIPE_LAT < 0) begin : g_bad_params
        $error("fft_stage_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [BW-1:0]   b_q, b_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [LOGN-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [BW-1:0]   tw_q, tw_d;

    logic            accept, last_bf, last_stage, drain_end, load_addr;
    logic [LOGN-1:0] half, grp, pos, calc_a, calc_b;
    logic [BW-1:0]   calc_tw;

    assign accept     = (state_q == ISSUE) && bf_ready;
    assign last_bf    = (b_q == B_LAST);
    assign last_stage = (stage_q == S_LAST);
    assign drain_end  = (drain_q == D_LAST);

    // FSM state register and the registered stage, butterfly and address state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            b_q      <= '0;
            drain_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            b_q      <= b_d;
            drain_q  <= drain_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    // Next-state logic. When PIPE_LAT is 0 the design skips DRAIN and goes straight
    // to the next stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                if (accept && last_bf) begin
                    if (PIPE_LAT > 0)    state_d = DRAIN;
                    else if (last_stage) state_d = DONE;
                end
            end
            DRAIN: begin
                if (drain_end) state_d = last_stage ? DONE : ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage, butterfly and drain counters. stage stays at its value through the run
    // and goes back to 0 after DONE.
    always_comb begin
        stage_d = stage_q;
        b_d     = b_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stage_d = '0;
                    b_d     = '0;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (last_bf) begin
                        b_d     = '0;
                        drain_d = '0;
                        if (PIPE_LAT == 0 && !last_stage) stage_d = stage_q + 1'b1;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    drain_d = '0;
                    if (!last_stage) stage_d = stage_q + 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE:    stage_d = '0;
            default: ;
        endcase
    end

    // Address generation from the next (stage, b) pair. The result is registered, so
    // the addresses are ready in the same cycle that bf_valid goes high.
    always_comb begin
        half    = LOGN'(1) << stage_d;
        grp     = LOGN'(b_d) >> stage_d;
        pos     = LOGN'(b_d) & (half - LOGN'(1));
        calc_a  = ((grp << stage_d) << 1) | pos;
        calc_b  = calc_a + half;
        calc_tw = BW'(pos << (S_LAST - stage_d));
    end

    // Load new operands only when a butterfly is about to be presented. At all other
    // times, including a stalled handshake, DRAIN and IDLE, the outputs hold.
    always_comb begin
        load_addr = (state_d == ISSUE) && ((state_q != ISSUE) || accept);
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        tw_d      = tw_q;
        if (load_addr) begin
            addr_a_d = calc_a;
            addr_b_d = calc_b;
            tw_d     = calc_tw;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        bf_valid = (state_q == ISSUE);
        busy     = (state_q == ISSUE) || (state_q == DRAIN);
        done     = (state_q == DONE);
        addr_a   = addr_a_q;
        addr_b   = addr_b_q;
        tw_idx   = tw_q;
        stage    = stage_q;
    end

endmodule
